if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Purpose : instruction fetch stage; owns the PC, drives instruction memory, registers IF/ID.
// Latency : one cycle from im_addr to ifid_instr/ifid_pc4/ifid_valid.
// Backpr. : stall holds PC and IF/ID; flush bubbles IF/ID and holds PC; br_taken wins over both.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   stall, flush          hold / bubble controls from the hazard unit
//   br_taken, br_target   fetch redirect (target is forced word aligned)
//   im_addr, im_instr     combinational instruction memory interface (im_addr == PC)
//   ifid_instr, ifid_pc4, ifid_valid   IF/ID pipeline register
//   halted                fetch is parked in HALT after fetching HALT_WORD
//   fetch_cnt             (only with IF_STAGE_PERF_CNT_EN) saturating count of valid IF/ID loads
//
// Optional feature macro: IF_STAGE_PERF_CNT_EN

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] ifid_instr_nxt;
    logic [31:0] ifid_pc4_nxt;
    logic        ifid_valid_nxt;
    logic        load_valid;   // this edge writes a real instruction into IF/ID

    // Low target bits are discarded by the word-alignment of the redirect.
    logic        unused_br_low;
    assign unused_br_low = ^br_target[1:0];

    // 32-bit add wraps naturally: FFFF_FFFC + 4 -> 0000_0000.
    assign pc_plus4 = pc + 32'd4;
    assign im_addr  = pc;
    assign halted   = (state == HALT);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ifid_instr_nxt = ifid_instr;
        ifid_pc4_nxt   = ifid_pc4;
        ifid_valid_nxt = ifid_valid;
        load_valid     = 1'b0;

        if (br_taken) begin
            // Redirect has top priority in both states and always leaves HALT.
            state_nxt      = RUN;
            pc_nxt         = {br_target[31:2], 2'b00};
            ifid_instr_nxt = 32'd0;
            ifid_pc4_nxt   = 32'd0;
            ifid_valid_nxt = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (flush) begin
                        ifid_instr_nxt = 32'd0;
                        ifid_pc4_nxt   = 32'd0;
                        ifid_valid_nxt = 1'b0;
                    end else if (!stall) begin
                        ifid_instr_nxt = im_instr;
                        ifid_pc4_nxt   = pc_plus4;
                        ifid_valid_nxt = 1'b1;
                        load_valid     = 1'b1;
                        if (im_instr == HALT_WORD) begin
                            // The halt word itself goes to decode; PC parks on it.
                            state_nxt = HALT;
                        end else begin
                            pc_nxt = pc_plus4;
                        end
                    end
                end
                HALT: begin
                    // stall and flush are ignored here; IF/ID is bubbled every cycle.
                    ifid_instr_nxt = 32'd0;
                    ifid_pc4_nxt   = 32'd0;
                    ifid_valid_nxt = 1'b0;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_pc4   <= ifid_pc4_nxt;
            ifid_valid <= ifid_valid_nxt;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
        end else if (load_valid && (fetch_cnt != 32'hFFFF_FFFF)) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`else
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Purpose : directed self-checking bench for if_stage.
// Latency : observes outputs 1 time unit after each rising edge.
// Backpr. : drives stall/flush/br_taken directly; memory is a combinational model.

module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    logic        halt_en;   // place HALT_WORD at address 0x10
    int          checks;
    int          errors;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .im_addr    (im_addr),
        .im_instr   (im_instr),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .halted     (halted)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt)
`endif
    );

    // Memory: word at address a is 0x0C00_0000 + a, except optional HALT word at 0x10.
    assign im_instr = (halt_en && im_addr == 32'h10) ? 32'hFFFF_FFFF : (32'h0C00_0000 + im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Tuple compared: {im_addr, ifid_instr, ifid_pc4, ifid_valid, halted}
    task automatic test_reset();
        halt_en = 1'b0;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid, halted} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got addr=%h instr=%h pc4=%h v=%b h=%b, want 0/0/0/0/0",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid, halted);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !==
                {32'(4 * (i + 1)), 32'h0C00_0000 + 32'(4 * i), 32'(4 * (i + 1)), 1'b1}) begin
                errors++;
                $display("FAIL seq[%0d]: got addr=%h instr=%h pc4=%h v=%b, want addr=%h instr=%h pc4=%h v=1",
                         i, im_addr, ifid_instr, ifid_pc4, ifid_valid,
                         4 * (i + 1), 32'h0C00_0000 + 4 * i, 4 * (i + 1));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();   // PC = 8, IF/ID holds word at 4
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h8, 32'h0C00_0004, 32'h8, 1'b1}) begin
                errors++;
                $display("FAIL stall[%0d]: got addr=%h instr=%h pc4=%h v=%b, want 8/0c000004/8/1",
                         i, im_addr, ifid_instr, ifid_pc4, ifid_valid);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'hC, 32'h0C00_0008, 32'hC, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: got addr=%h instr=%h pc4=%h v=%b, want c/0c000008/c/1",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_branch();
        br_taken  = 1'b1;
        stall     = 1'b1;
        br_target = 32'h0000_0043;
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h40, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL branch_stall: got addr=%h instr=%h pc4=%h v=%b, want 40/0/0/0",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid);
        end
        idle_inputs();
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h44, 32'h0C00_0040, 32'h44, 1'b1}) begin
            errors++;
            $display("FAIL branch_resume: got addr=%h instr=%h pc4=%h v=%b, want 44/0c000040/44/1",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        stall = 1'b1;   // flush outranks stall
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h44, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL flush: got addr=%h instr=%h pc4=%h v=%b, want 44/0/0/0",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid);
        end
        idle_inputs();
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h48, 32'h0C00_0044, 32'h48, 1'b1}) begin
            errors++;
            $display("FAIL flush_resume: got addr=%h instr=%h pc4=%h v=%b, want 48/0c000044/48/1",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_halt();
        halt_en = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) step();   // PC = 0x10
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid, halted} !== {32'h10, 32'hFFFF_FFFF, 32'h14, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL halt_enter: got addr=%h instr=%h pc4=%h v=%b h=%b, want 10/ffffffff/14/1/1",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid, halted);
        end
        stall = 1'b1;   // ignored in HALT: bubble still inserted
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid, halted} !== {32'h10, 32'h0, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL halt_bubble: got addr=%h instr=%h pc4=%h v=%b h=%b, want 10/0/0/0/1",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid, halted);
        end
        idle_inputs();
        br_taken = 1'b1;
        br_target = 32'h0;
        step();
        checks++;
        if ({im_addr, ifid_valid, halted} !== {32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL halt_exit: got addr=%h v=%b h=%b, want 0/0/0", im_addr, ifid_valid, halted);
        end
        idle_inputs();
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h4, 32'h0C00_0000, 32'h4, 1'b1}) begin
            errors++;
            $display("FAIL halt_resume: got addr=%h instr=%h pc4=%h v=%b, want 4/0c000000/4/1",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_halt_stalled_and_reset();
        halt_en = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) step();   // PC = 0x10 with HALT word on the bus
        stall = 1'b1;
        step();
        checks++;
        if ({im_addr, halted} !== {32'h10, 1'b0}) begin
            errors++;
            $display("FAIL halt_while_stalled: got addr=%h h=%b, want 10/0", im_addr, halted);
        end
        stall = 1'b0;
        step();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_after_release: got h=%b, want 1", halted);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid, halted} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_halt: got addr=%h instr=%h pc4=%h v=%b h=%b, want 0/0/0/0/0",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid, halted);
        end
        halt_en = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFE;
        step();
        idle_inputs();
        checks++;
        if (im_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_target: got addr=%h, want fffffffc", im_addr);
        end
        step();
        checks++;
        if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h0, 32'h0BFF_FFFC, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_advance: got addr=%h instr=%h pc4=%h v=%b, want 0/0bfffffc/0/1",
                     im_addr, ifid_instr, ifid_pc4, ifid_valid);
        end
    endtask

`ifdef IF_STAGE_PERF_CNT_EN
    task automatic test_perf_cnt();
        halt_en = 1'b0;
        do_reset();
        checks++;
        if (fetch_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d, want 0", fetch_cnt);
        end
        for (int i = 0; i < 5; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        checks++;
        if (fetch_cnt !== 32'd5) begin
            errors++;
            $display("FAIL perf_count: got %0d, want 5", fetch_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (fetch_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_rst: got %0d, want 0", fetch_cnt);
        end
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        halt_en = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush();
        test_halt();
        test_halt_stalled_and_reset();
        test_wrap();
`ifdef IF_STAGE_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
